// File: rtl/cv32e40x_write_buffer_if.sv
// Handshake/bus bundle between the LSU-side MPU and the data OBI interface.
// trans_* layout: addr[79:48] we[47] be[46:43] wdata[42:11] memtype[10:9] prot[8:6] atop[5:0].
interface cv32e40x_write_buffer_if;
  logic        valid_i;
  logic        ready_o;
  logic [79:0] trans_i;
  logic        valid_o;
  logic        ready_i;
  logic [79:0] trans_o;
  logic        empty_o;

  modport slave (
    input  valid_i, trans_i, ready_i,
    output ready_o, valid_o, trans_o, empty_o
  );

  modport master (
    output valid_i, trans_i, ready_i,
    input  ready_o, valid_o, trans_o, empty_o
  );
endinterface

// File: rtl/cv32e40x_write_buffer.sv
// Data-side write buffer: absorbs bufferable writes while the OBI bus stalls.
// Build with CV32E40X_WBUF_EN to enable the FIFO; otherwise a pure pass-through.
module cv32e40x_write_buffer #(
  parameter int DEPTH = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  cv32e40x_write_buffer_if.slave  bus
);

`ifdef CV32E40X_WBUF_EN

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  memtype;
    logic [2:0]  prot;
    logic [5:0]  atop;
  } obi_data_req_t;

  obi_data_req_t  trans_in;
  obi_data_req_t  mem_q [DEPTH];
  obi_data_req_t  mem_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;

  logic bufferable;
  logic occupied;
  logic full;
  logic enq;
  logic deq;

  assign trans_in = bus.trans_i;

  // While reset is asserted the stale count must not steer the outputs.
  always_comb begin
    bufferable  = trans_in.we && trans_in.memtype[0] && (trans_in.atop == 6'd0);
    occupied    = rst_n && (count_q != '0);
    full        = (count_q == CNT_FULL);
    enq         = 1'b0;
    deq         = 1'b0;
    bus.valid_o = bus.valid_i;
    bus.trans_o = bus.trans_i;
    bus.ready_o = bus.ready_i;
    if (!occupied) begin
      enq         = rst_n && bus.valid_i && bufferable && !bus.ready_i;
      bus.ready_o = bus.ready_i || enq;
    end else begin
      // Reads and non-bufferable writes wait here until the buffer drains.
      enq         = bus.valid_i && bufferable && !full;
      deq         = bus.ready_i;
      bus.valid_o = 1'b1;
      bus.trans_o = mem_q[rptr_q];
      bus.ready_o = enq;
    end
    bus.empty_o = !occupied;
  end

  always_comb begin
    count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    mem_d   = mem_q;
    if (deq) begin
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
    end
    if (enq) begin
      wptr_d         = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
      mem_d[wptr_q]  = trans_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
    end else begin
      count_q <= count_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
    end
  end

  // Payload storage carries no reset; validity lives entirely in count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`else

  logic unused_ok;

  assign bus.valid_o = bus.valid_i;
  assign bus.trans_o = bus.trans_i;
  assign bus.ready_o = bus.ready_i;
  assign bus.empty_o = 1'b1;
  assign unused_ok   = ^{clk, rst_n, 32'(DEPTH)};

`endif

endmodule

// File: doc/cv32e40x_write_buffer.md
CV32E40X_WRITE_BUFFER -- requirements
Module: cv32e40x_write_buffer

Placement: data side, between the LSU instance of cv32e40x_mpu and cv32e40x_data_obi_interface; absorbs bufferable writes while the bus stalls.

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered write entries (legal 1..4).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port valid_i  input  1  upstream transaction valid.
REQ-005 SHALL have port ready_o  output  1  upstream transaction accepted.
REQ-006 SHALL have port trans_i  input  80  obi_data_req_t request: addr[32], we, be[4], wdata[32], memtype[2], prot[3], atop[6].
REQ-007 SHALL have port valid_o  output  1  downstream transaction valid.
REQ-008 SHALL have port ready_i  input  1  downstream accepts transaction.
REQ-009 SHALL have port trans_o  output  80  obi_data_req_t request toward bus interface.
REQ-010 SHALL have port empty_o  output  1  no buffered writes pending (for fence, WFI, debug entry).

Function
REQ-011 A transaction SHALL be bufferable iff we=1, memtype[0]=1 and atop=0.
REQ-012 Storage SHALL be a circular FIFO of DEPTH entries: read/write pointers wrap modulo DEPTH; count 0..DEPTH.
REQ-013 count==0: pass-through. valid_o=valid_i, trans_o=trans_i, ready_o=ready_i, zero latency.
REQ-014 count==0, valid_i, bufferable, ready_i=0: SHALL enqueue trans_i, assert ready_o, count becomes 1.
REQ-015 count>0: valid_o=1 and trans_o=FIFO head, independent of upstream.
REQ-016 count>0 and count<DEPTH: ready_o=1 only for a valid bufferable transaction, which is enqueued.
REQ-017 count>0: reads and non-bufferable writes SHALL see ready_o=0 until count==0 (ordering).
REQ-018 count==DEPTH: ready_o=0 for all transactions.
REQ-019 count>0 and ready_i: head dequeued, read pointer advances.
REQ-020 Simultaneous enqueue and dequeue: count unchanged and both pointers advance, including at count==DEPTH-1 and on wrap.
REQ-021 trans_o fields SHALL equal the enqueued fields bit-exact; memtype passes through unmodified.
REQ-022 empty_o = (count==0), registered-state derived, no dependence on valid_i.
REQ-023 valid_o SHALL NOT deassert while count>0 and ready_i=0 (OBI stability); trans_o SHALL stay stable over the same interval.
REQ-024 Upstream handshake: transfer occurs when valid_i && ready_o. ready_o MAY depend combinationally on ready_i only when count==0.

Reset
REQ-025 rst_n=0 on a clock edge SHALL clear count, both pointers and any valid state; FIFO data need not reset.
REQ-026 During and after reset: valid_o=valid_i (pass-through), empty_o=1. Reset mid-operation discards buffered writes without emitting them.

Configuration
REQ-027 Macro CV32E40X_WBUF_EN. Defined: behaviour per REQ-011..REQ-024.
REQ-028 Macro undefined: no storage. valid_o=valid_i, trans_o=trans_i, ready_o=ready_i, empty_o=1 constantly. DEPTH is ignored.

Verification
REQ-029 count=0, ready_i=1, read addr 0x1000 -> same-cycle valid_o=1, trans_o.addr=0x1000, ready_o=1, empty_o stays 1.
REQ-030 ready_i=0; bufferable writes 0x2000/0x2004 on consecutive cycles, DEPTH=2 -> both accepted, empty_o=0 after the first. Third write sees ready_o=0. ready_i=1 for 2 cycles -> bus gets 0x2000 then 0x2004, empty_o=1.
REQ-031 count=1 (0x3000 buffered); valid read 0x4000 -> ready_o=0 until 0x3000 is dequeued. The read then passes through the next cycle it is presented.
REQ-032 DEPTH=2, count=1; enqueue and dequeue in the same cycle repeated 5 times -> count stays 1, order preserved across pointer wrap.
REQ-033 count=2, rst_n=0 one cycle -> next cycle empty_o=1, valid_o=valid_i, buffered writes never appear on trans_o.
REQ-034 Macro undefined: random traffic with ready_i stalls -> outputs equal inputs each cycle, empty_o=1.
